// File: rtl/kmsink_pkg.sv
// Shared types and helpers for the Kmeans result sink.
// Optional max tracking in the top level is enabled by defining KMSINK_MAXTRACK_EN.
package kmsink_pkg;

    localparam int DATA_W_DEF = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_COLLECT,
        ST_DONE
    } state_t;

    // Bits needed to index `value` distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/kmsink_fifo.sv
// Single-clock FIFO with exact occupancy count; simultaneous push and pop are
// accepted when full, and an empty FIFO never bypasses wdata to rdata.
module kmsink_fifo
    import kmsink_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     fill
);

    localparam int AW = clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (fill == FW'(DEPTH));
    assign empty   = (fill == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and fill define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/kmeans_result_sink.sv
// Run controller and result consumer for the Kmeans core: start pulse, result
// capture into a FIFO, strobe-gap watchdog. Define KMSINK_MAXTRACK_EN for max_y tracking.
module kmeans_result_sink
    import kmsink_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 16,
    parameter int NUM_RESULTS = 8,
    parameter int TIMEOUT     = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run_req,
    output logic                    km_start,
    input  logic [DATA_W-1:0]       km_y,
    input  logic                    km_tr1,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    input  logic                    rd_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic                    overflow,
    output logic [clog2(DEPTH):0]   fill,
    output logic [DATA_W-1:0]       max_y
);

    localparam int CW = clog2(NUM_RESULTS + 1);
    localparam int WW = clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   res_cnt;
    logic [WW-1:0]   wd_cnt;
    logic            run_go;
    logic            strobe;
    logic            run_complete;
    logic            wd_expire;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    assign run_go       = (state == ST_IDLE) && run_req;
    assign strobe       = (state == ST_COLLECT) && km_tr1;
    assign run_complete = (res_cnt == CW'(NUM_RESULTS));
    // A strobe in the expiry cycle wins over the timeout.
    assign wd_expire    = (state == ST_COLLECT) && !run_complete && !km_tr1
                          && (wd_cnt == WW'(TIMEOUT));

    assign km_start = (state == ST_START);
    assign busy     = (state == ST_START) || (state == ST_COLLECT);
    assign done     = (state == ST_DONE);
    assign rd_valid = !fifo_empty;
    assign pop      = rd_valid && rd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets its default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (run_req) state_nxt = ST_START;
            ST_START:   state_nxt = ST_COLLECT;
            ST_COLLECT: if (run_complete || wd_expire) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_cnt     <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
        end else if (run_go) begin
            res_cnt     <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (strobe) begin
                res_cnt <= res_cnt + CW'(1);
                wd_cnt  <= '0;
            end else if ((state == ST_COLLECT) && (wd_cnt != WW'(TIMEOUT))) begin
                wd_cnt  <= wd_cnt + WW'(1);
            end
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
            if (strobe && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef KMSINK_MAXTRACK_EN
    logic [DATA_W-1:0] max_q;

    // Dropped strobes still take part in the maximum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q <= '0;
        end else if (run_go) begin
            max_q <= '0;
        end else if (strobe && (km_y > max_q)) begin
            max_q <= km_y;
        end
    end

    assign max_y = max_q;
`else
    assign max_y = '0;
`endif

    kmsink_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (strobe),
        .pop    (pop),
        .wdata  (km_y),
        .rdata  (rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .fill   (fill)
    );

endmodule

// File: tb/tb_kmeans_result_sink.sv
// Scoreboard bench for kmeans_result_sink: a queue model of the FIFO and run flags
// checked every cycle, plus directed checks on run timing, timeout and overflow.
module tb_kmeans_result_sink;

    localparam int DATA_W  = 18;
    localparam int DEPTH   = 16;
    localparam int NUM_RES = 8;
    localparam int TIMEOUT = 1023;

`ifdef KMSINK_MAXTRACK_EN
    localparam logic [DATA_W-1:0] MAX_EXP = 18'h3FFFF;
`else
    localparam logic [DATA_W-1:0] MAX_EXP = 18'h0;
`endif

    logic              clk;
    logic              reset;
    logic              run_req;
    logic              km_start;
    logic [DATA_W-1:0] km_y;
    logic              km_tr1;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic              overflow;
    logic [4:0]        fill;
    logic [DATA_W-1:0] max_y;

    kmeans_result_sink #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .NUM_RESULTS (NUM_RES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run_req     (run_req),
        .km_start    (km_start),
        .km_y        (km_y),
        .km_tr1      (km_tr1),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .overflow    (overflow),
        .fill        (fill),
        .max_y       (max_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: FIFO contents, sticky overflow and run maximum.
    logic [DATA_W-1:0] model_q [$];
    logic              model_ovf = 1'b0;
    logic [DATA_W-1:0] model_max = '0;
    logic              push_exp  = 1'b0;
    logic              run_acc   = 1'b0;
    logic              rand_ready = 1'b0;
    int                start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model, then advance the model by this cycle's inputs.
    always @(negedge clk) begin
        if (reset) begin
            check("fill", 32'(fill), 32'(model_q.size()));
            check("rd_valid", 32'(rd_valid), 32'(model_q.size() > 0));
            if (rd_valid && model_q.size() > 0) check("rd_data", 32'(rd_data), 32'(model_q[0]));
            check("overflow", 32'(overflow), 32'(model_ovf));
            check("max_y", 32'(max_y), 32'(model_max));
            if (km_start) start_cnt++;
            if (rd_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (run_acc) begin
                model_ovf = 1'b0;
                model_max = '0;
            end
            if (push_exp) begin
`ifdef KMSINK_MAXTRACK_EN
                if (km_y > model_max) model_max = km_y;
`endif
                if (model_q.size() == DEPTH) model_ovf = 1'b1;
                else model_q.push_back(km_y);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic strobe(input logic [DATA_W-1:0] y, input logic accepted);
        km_tr1   = 1'b1;
        km_y     = y;
        push_exp = accepted;
        tick();
        km_tr1   = 1'b0;
        push_exp = 1'b0;
    endtask

    // Issue run_req from IDLE; returns one cycle into COLLECT.
    task automatic start_run();
        run_req = 1'b1;
        run_acc = 1'b1;
        tick();
        run_req = 1'b0;
        run_acc = 1'b0;
        check("km_start_on", 32'(km_start), 32'd1);
        tick();
        check("km_start_off", 32'(km_start), 32'd0);
        check("busy_collect", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = 0;
        while (!done && cycles < bound) begin
            tick();
            cycles++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        rd_ready = 1'b0;
        check("drained", 32'(fill), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int s0;
        logic [DATA_W-1:0] y;

        reset   = 1'b0;
        run_req = 1'b0;
        km_y    = '0;
        km_tr1  = 1'b0;
        rd_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(km_start), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_max", 32'(max_y), 32'd0);
        reset = 1'b1;
        tick();

        // Reset during COLLECT with three entries queued.
        start_run();
        for (int i = 0; i < 3; i++) strobe(DATA_W'(i + 10), 1'b1);
        #2;
        reset = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        model_max = '0;
        #1;
        check("mid_rst_fill", 32'(fill), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_flags", 32'({km_start, done, timeout_err, overflow}), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Normal run, results 1..8, done one cycle after the last strobe.
        start_run();
        for (int i = 1; i <= NUM_RES; i++) strobe(DATA_W'(i), 1'b1);
        check("done_early", 32'(done), 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd1);
        tick();
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("normal_to", 32'(timeout_err), 32'd0);
        check("normal_fill", 32'(fill), 32'd8);
        drain();

        // Timeout: three strobes then silence.
        start_run();
        for (int i = 0; i < 3; i++) strobe(DATA_W'($urandom), 1'b1);
        wait_done(2000, cyc);
        check("timeout_cycles", 32'(cyc), 32'd1024);
        check("timeout_err", 32'(timeout_err), 32'd1);
        check("timeout_fill", 32'(fill), 32'd3);
        tick();
        drain();

        // Strobe arriving in the cycle the watchdog reaches its limit.
        start_run();
        repeat (TIMEOUT) tick();
        for (int i = 0; i < NUM_RES; i++) strobe(DATA_W'($urandom), 1'b1);
        wait_done(3, cyc);
        check("edge_strobe_cycles", 32'(cyc), 32'd1);
        check("edge_strobe_to", 32'(timeout_err), 32'd0);
        tick();
        drain();

        // Overflow: fill with two runs, third run drops everything.
        for (int r = 0; r < 3; r++) begin
            start_run();
            for (int i = 0; i < NUM_RES; i++) strobe(DATA_W'($urandom), 1'b1);
            wait_done(5, cyc);
            tick();
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_fill", 32'(fill), 32'd16);
        start_run();
        check("ovf_cleared", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < NUM_RES; i++) strobe(DATA_W'($urandom), 1'b1);
        rd_ready = 1'b0;
        wait_done(5, cyc);
        tick();
        check("full_pop_push_ovf", 32'(overflow), 32'd0);
        check("full_pop_push_fill", 32'(fill), 32'd16);
        drain();

        // Strobes in IDLE are ignored; the next run still needs all eight.
        for (int i = 0; i < 3; i++) strobe(DATA_W'(i + 100), 1'b0);
        tick();
        check("idle_strobe_fill", 32'(fill), 32'd0);
        start_run();
        for (int i = 0; i < NUM_RES - 1; i++) strobe(DATA_W'(i), 1'b1);
        tick();
        check("idle_strobe_nocount", 32'(done), 32'd0);
        strobe(DATA_W'(7), 1'b1);
        wait_done(3, cyc);
        check("idle_strobe_done", 32'(cyc), 32'd1);
        tick();
        drain();

        // run_req held high for the whole run gives a single start pulse.
        s0 = start_cnt;
        run_req = 1'b1;
        run_acc = 1'b1;
        tick();
        run_acc = 1'b0;
        tick();
        for (int i = 0; i < NUM_RES; i++) strobe(DATA_W'($urandom), 1'b1);
        wait_done(5, cyc);
        run_req = 1'b0;
        tick();
        tick();
        check("single_start", 32'(start_cnt - s0), 32'd1);
        drain();

        // Max tracking.
        start_run();
        strobe(18'd5, 1'b1);
        strobe(18'h3FFFF, 1'b1);
        strobe(18'd7, 1'b1);
        for (int i = 0; i < NUM_RES - 3; i++) strobe(DATA_W'(i), 1'b1);
        wait_done(5, cyc);
        tick();
        check("max_value", 32'(max_y), 32'(MAX_EXP));
        start_run();
        check("max_cleared", 32'(max_y), 32'd0);
        for (int i = 0; i < NUM_RES; i++) strobe(DATA_W'(i), 1'b1);
        wait_done(5, cyc);
        tick();
        drain();

        // Random runs with random gaps and random consumer back-pressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            start_run();
            for (int i = 0; i < NUM_RES; i++) begin
                repeat ($urandom_range(0, 4)) tick();
                y = DATA_W'($urandom);
                strobe(y, 1'b1);
            end
            wait_done(5, cyc);
            check("rand_to", 32'(timeout_err), 32'd0);
            tick();
        end
        rand_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
